// File: rtl/sobel_controller.sv
`default_nettype none
// ============================================================================
// Module      : sobel_controller
// Description : Sequences an N-wide combinational Sobel accelerator over a
//               greyscale image. Walks the image in vertical strips of N
//               output columns, fetching N+2-byte input chunks row by row,
//               steering the row-register shift/clear controls and issuing
//               masked writes of each output row chunk.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_controller #(
    parameter int NUM_SOBEL_ACCELERATORS = 16,
    parameter int ADDR_WIDTH             = 32,
    parameter int DIM_WIDTH              = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              go,
    input  logic [DIM_WIDTH-1:0]              cfg_n_rows,
    input  logic [DIM_WIDTH-1:0]              cfg_n_cols,
    input  logic [ADDR_WIDTH-1:0]             cfg_in_base,
    input  logic [ADDR_WIDTH-1:0]             cfg_out_base,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_err,
    output logic                              sctl2mem_rd_req,
    output logic [ADDR_WIDTH-1:0]             sctl2mem_rd_addr,
    input  logic                              mem2sctl_rd_valid,
    output logic [1:0]                        sctl2srow_op,
    output logic                              sctl2swt_write_en,
    output logic [ADDR_WIDTH-1:0]             sctl2swt_write_addr,
    output logic [NUM_SOBEL_ACCELERATORS-1:0] sctl2swt_write_mask,
    input  logic                              swt2sctl_write_ack
);

    // Strip offset needs headroom above the column count for the final +N step.
    localparam int c_SW = DIM_WIDTH + $clog2(NUM_SOBEL_ACCELERATORS + 1) + 1;

    localparam logic [1:0] c_OP_HOLD  = 2'b00;
    localparam logic [1:0] c_OP_CLEAR = 2'b01;
    localparam logic [1:0] c_OP_SHIFT = 2'b10;

    localparam logic [c_SW-1:0]       c_STRIP_STEP = c_SW'(NUM_SOBEL_ACCELERATORS);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_STEP  = ADDR_WIDTH'(NUM_SOBEL_ACCELERATORS);
    localparam logic [DIM_WIDTH-1:0]  c_MIN_DIM    = DIM_WIDTH'(3);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_ADV   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                            r_state;
    logic [DIM_WIDTH-1:0]              r_n_rows;
    logic [DIM_WIDTH-1:0]              r_n_cols;
    logic [DIM_WIDTH-1:0]              r_out_cols;
    logic [DIM_WIDTH-1:0]              r_row;
    logic [c_SW-1:0]                   r_strip;
    logic [ADDR_WIDTH-1:0]             r_in_strip;
    logic [ADDR_WIDTH-1:0]             r_out_strip;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_cfg_err;
    logic                              r_rd_req;
    logic [ADDR_WIDTH-1:0]             r_rd_addr;
    logic                              r_write_en;
    logic [ADDR_WIDTH-1:0]             r_write_addr;
    logic [NUM_SOBEL_ACCELERATORS-1:0] r_write_mask;

    logic                              w_cfg_bad;
    logic [c_SW-1:0]                   w_out_cols_ext;
    logic [c_SW-1:0]                   w_strip_next;
    logic [DIM_WIDTH-1:0]              w_row_next;
    logic                              w_more_rows;
    logic                              w_more_strips;
    logic [NUM_SOBEL_ACCELERATORS-1:0] w_mask;
    logic [1:0]                        w_srow_op;

    assign w_cfg_bad      = (cfg_n_rows < c_MIN_DIM) || (cfg_n_cols < c_MIN_DIM);
    assign w_out_cols_ext = c_SW'(r_out_cols);
    assign w_strip_next   = r_strip + c_STRIP_STEP;
    assign w_row_next     = r_row + DIM_WIDTH'(1);
    assign w_more_rows    = (w_row_next < r_n_rows);
    assign w_more_strips  = (w_strip_next < w_out_cols_ext);

    // Byte lane j is live only while its output column lies inside the image.
    for (genvar j = 0; j < NUM_SOBEL_ACCELERATORS; j++) begin : g_mask
        assign w_mask[j] = ((r_strip + c_SW'(j)) < w_out_cols_ext);
    end

    // Row-register control: clear for the single CLEAR cycle, shift exactly when read data lands.
    always_comb begin
        w_srow_op = c_OP_HOLD;
        if (r_state == S_CLEAR) begin
            w_srow_op = c_OP_CLEAR;
        end else if ((r_state == S_READ) && mem2sctl_rd_valid) begin
            w_srow_op = c_OP_SHIFT;
        end
    end

    // Strip/row sequencer with registered handshake outputs and adder-only address walk.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_n_rows     <= '0;
            r_n_cols     <= '0;
            r_out_cols   <= '0;
            r_row        <= '0;
            r_strip      <= '0;
            r_in_strip   <= '0;
            r_out_strip  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_rd_req     <= 1'b0;
            r_rd_addr    <= '0;
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_write_mask <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_busy      <= 1'b1;
                        r_n_rows    <= cfg_n_rows;
                        r_n_cols    <= cfg_n_cols;
                        r_out_cols  <= cfg_n_cols - DIM_WIDTH'(2);
                        r_strip     <= '0;
                        r_in_strip  <= cfg_in_base;
                        r_out_strip <= cfg_out_base;
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_cfg_err <= 1'b0;
                            r_state   <= S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    // Each strip restarts from its own top-left corner.
                    r_row        <= '0;
                    r_rd_addr    <= r_in_strip;
                    r_write_addr <= r_out_strip;
                    r_write_mask <= w_mask;
                    r_rd_req     <= 1'b1;
                    r_state      <= S_READ;
                end
                S_READ: begin
                    if (mem2sctl_rd_valid) begin
                        r_rd_req  <= 1'b0;
                        r_rd_addr <= r_rd_addr + ADDR_WIDTH'(r_n_cols);
                        if (r_row >= DIM_WIDTH'(2)) begin
                            r_write_en <= 1'b1;
                            r_state    <= S_WRITE;
                        end else begin
                            r_state <= S_ADV;
                        end
                    end
                end
                S_WRITE: begin
                    if (swt2sctl_write_ack) begin
                        r_write_en   <= 1'b0;
                        r_write_addr <= r_write_addr + ADDR_WIDTH'(r_out_cols);
                        r_state      <= S_ADV;
                    end
                end
                S_ADV: begin
                    r_row <= w_row_next;
                    if (w_more_rows) begin
                        r_rd_req <= 1'b1;
                        r_state  <= S_READ;
                    end else begin
                        r_strip     <= w_strip_next;
                        r_in_strip  <= r_in_strip + c_ADDR_STEP;
                        r_out_strip <= r_out_strip + c_ADDR_STEP;
                        r_state     <= w_more_strips ? S_CLEAR : S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy                = r_busy;
    assign done                = r_done;
    assign cfg_err             = r_cfg_err;
    assign sctl2mem_rd_req     = r_rd_req;
    assign sctl2mem_rd_addr    = r_rd_addr;
    assign sctl2srow_op        = w_srow_op;
    assign sctl2swt_write_en   = r_write_en;
    assign sctl2swt_write_addr = r_write_addr;
    assign sctl2swt_write_mask = r_write_mask;

endmodule
`default_nettype wire

// File: tb/tb_sobel_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_controller
// Description : Self-checking bench for sobel_controller. A reference model
//               expands the image geometry into the expected read, write,
//               mask and row-content sequences; memory and write responders
//               insert randomised latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_controller;

    localparam int c_N  = 4;
    localparam int c_AW = 32;
    localparam int c_DW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              go;
    logic [c_DW-1:0]   cfg_n_rows;
    logic [c_DW-1:0]   cfg_n_cols;
    logic [c_AW-1:0]   cfg_in_base;
    logic [c_AW-1:0]   cfg_out_base;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic              rd_req;
    logic [c_AW-1:0]   rd_addr;
    logic              rd_valid;
    logic [1:0]        srow_op;
    logic              write_en;
    logic [c_AW-1:0]   write_addr;
    logic [c_N-1:0]    write_mask;
    logic              write_ack;

    sobel_controller #(
        .NUM_SOBEL_ACCELERATORS (c_N),
        .ADDR_WIDTH             (c_AW),
        .DIM_WIDTH              (c_DW)
    ) u_dut (
        .clk                 (clk),
        .reset               (reset),
        .go                  (go),
        .cfg_n_rows          (cfg_n_rows),
        .cfg_n_cols          (cfg_n_cols),
        .cfg_in_base         (cfg_in_base),
        .cfg_out_base        (cfg_out_base),
        .busy                (busy),
        .done                (done),
        .cfg_err             (cfg_err),
        .sctl2mem_rd_req     (rd_req),
        .sctl2mem_rd_addr    (rd_addr),
        .mem2sctl_rd_valid   (rd_valid),
        .sctl2srow_op        (srow_op),
        .sctl2swt_write_en   (write_en),
        .sctl2swt_write_addr (write_addr),
        .sctl2swt_write_mask (write_mask),
        .swt2sctl_write_ack  (write_ack)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Observed traffic
    int unsigned    got_rd[$];
    int unsigned    got_wr[$];
    logic [c_N-1:0] got_mask[$];
    int n_clear, n_shift, n_stray, n_done, n_unstable, cyc, done_cyc;
    logic busy_at_done, busy_c1;

    // Expected traffic from the model
    int unsigned    exp_rd[$];
    int unsigned    exp_wr[$];
    logic [c_N-1:0] exp_mask[$];
    int unsigned    exp_row1[$];
    int unsigned    exp_row3[$];
    int exp_clear;

    // Row-register model: each row holds the address it was loaded from
    int unsigned r1, r2, r3;

    // Responder state
    int rd_lat_min, rd_lat_max, wr_lat_min, wr_lat_max;
    int rd_wait, wr_wait;
    logic rd_pend, wr_pend;
    logic [c_AW-1:0] rd_hold;
    logic [c_AW+c_N-1:0] wr_hold;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: respond to requests after the edge, then sample the combinational row op.
    task automatic cycle();
        int k;
        @(negedge clk);
        rd_valid  = 1'b0;
        write_ack = 1'b0;
        if (rd_req) begin
            if (!rd_pend) begin
                rd_pend = 1'b1;
                rd_wait = $urandom_range(rd_lat_max, rd_lat_min);
                rd_hold = rd_addr;
            end else if (rd_addr !== rd_hold) begin
                n_unstable++;
            end
            if (rd_wait == 0) begin
                rd_valid = 1'b1;
                rd_pend  = 1'b0;
                got_rd.push_back(rd_addr);
            end else begin
                rd_wait--;
            end
        end
        if (write_en) begin
            if (!wr_pend) begin
                wr_pend = 1'b1;
                wr_wait = $urandom_range(wr_lat_max, wr_lat_min);
                wr_hold = {write_addr, write_mask};
                k = got_wr.size();
                if (k < exp_row1.size()) begin
                    check("row1_src", r1, exp_row1[k]);
                    check("row3_src", r3, exp_row3[k]);
                end
            end else if ({write_addr, write_mask} !== wr_hold) begin
                n_unstable++;
            end
            if (wr_wait == 0) begin
                write_ack = 1'b1;
                wr_pend   = 1'b0;
                got_wr.push_back(write_addr);
                got_mask.push_back(write_mask);
            end else begin
                wr_wait--;
            end
        end
        #1;
        cyc++;
        if (cyc == 1) busy_c1 = busy;
        case (srow_op)
            2'b01: begin n_clear++; r1 = 0; r2 = 0; r3 = 0; end
            2'b10: begin
                n_shift++;
                if (!rd_valid) n_stray++;
                r1 = r2; r2 = r3; r3 = rd_addr;
            end
            2'b11: n_stray++;
            default: ;
        endcase
        if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
            busy_at_done = busy;
        end
    endtask

    task automatic clear_logs();
        got_rd.delete(); got_wr.delete(); got_mask.delete();
        n_clear = 0; n_shift = 0; n_stray = 0; n_done = 0; n_unstable = 0;
        cyc = 0; done_cyc = -1; busy_at_done = 1'b1; busy_c1 = 1'b0;
        rd_pend = 1'b0; wr_pend = 1'b0; rd_wait = 0; wr_wait = 0;
    endtask

    // Expand the geometry into the strip-by-strip traffic it implies.
    task automatic build_model(input int R, input int C, input int unsigned ib, input int unsigned ob);
        logic [c_N-1:0] m;
        exp_rd.delete(); exp_wr.delete(); exp_mask.delete();
        exp_row1.delete(); exp_row3.delete();
        exp_clear = 0;
        if (R >= 3 && C >= 3) begin
            for (int s = 0; s < C - 2; s += c_N) begin
                exp_clear++;
                for (int r = 0; r < R; r++) begin
                    exp_rd.push_back(ib + r * C + s);
                    if (r >= 2) begin
                        exp_wr.push_back(ob + (r - 2) * (C - 2) + s);
                        for (int j = 0; j < c_N; j++) m[j] = (s + j < C - 2);
                        exp_mask.push_back(m);
                        exp_row1.push_back(ib + (r - 2) * C + s);
                        exp_row3.push_back(ib + r * C + s);
                    end
                end
            end
        end
    endtask

    task automatic run_case(input string nm, input int R, input int C,
                            input int unsigned ib, input int unsigned ob,
                            input logic extra_go);
        logic bad;
        bad = (R < 3) || (C < 3);
        build_model(R, C, ib, ob);
        clear_logs();
        cfg_n_rows = c_DW'(R); cfg_n_cols = c_DW'(C);
        cfg_in_base = ib; cfg_out_base = ob;
        go = 1'b1;
        cycle();
        go = 1'b0;
        // Scramble the cfg inputs: only the values latched at go may matter.
        cfg_n_rows = c_DW'($urandom); cfg_n_cols = c_DW'($urandom);
        cfg_in_base = $urandom; cfg_out_base = $urandom;
        for (int k = 0; k < 4000 && n_done == 0; k++) begin
            go = extra_go && (k == 6 || k == 20);
            cycle();
        end
        go = 1'b0;
        if (n_done == 0) check({nm, "_timeout"}, 0, 1);
        for (int k = 0; k < 3; k++) cycle();
        check({nm, "_done_cnt"}, n_done, 1);
        check({nm, "_busy_at_done"}, busy_at_done, 0);
        check({nm, "_cfg_err"}, cfg_err, bad);
        check({nm, "_n_reads"}, got_rd.size(), exp_rd.size());
        check({nm, "_n_writes"}, got_wr.size(), exp_wr.size());
        check({nm, "_n_clears"}, n_clear, exp_clear);
        check({nm, "_n_shifts"}, n_shift, exp_rd.size());
        check({nm, "_stray_op"}, n_stray, 0);
        check({nm, "_unstable"}, n_unstable, 0);
        if (bad) begin
            check({nm, "_done_lat"}, done_cyc, 2);
        end else begin
            check({nm, "_busy_c1"}, busy_c1, 1);
        end
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
            check($sformatf("%s_rd%0d", nm, i), got_rd[i], exp_rd[i]);
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            check($sformatf("%s_wa%0d", nm, i), got_wr[i], exp_wr[i]);
            check($sformatf("%s_wm%0d", nm, i), got_mask[i], exp_mask[i]);
        end
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; rd_valid = 1'b0; write_ack = 1'b0;
        cfg_n_rows = '0; cfg_n_cols = '0; cfg_in_base = '0; cfg_out_base = '0;
        r1 = 0; r2 = 0; r3 = 0;
        rd_lat_min = 0; rd_lat_max = 0; wr_lat_min = 0; wr_lat_max = 0;
        exp_row1.delete(); exp_row3.delete();
        clear_logs();
        repeat (3) cycle();
        check("rst_ctl", {busy, done, cfg_err, rd_req, write_en, srow_op, write_mask}, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", write_addr, 0);
        reset = 1'b0;
        cycle();

        // Basic single strip and two-strip partial-mask geometries, immediate handshakes
        run_case("t1", 5, 6, 32'h1000, 32'h2000, 1'b0);
        run_case("t2", 3, 7, 32'h0, 32'h100, 1'b0);

        // Fixed slow handshakes
        rd_lat_min = 3; rd_lat_max = 3; wr_lat_min = 2; wr_lat_max = 2;
        run_case("slow", 6, 11, 32'h4000, 32'h8000, 1'b0);
        rd_lat_min = 0; rd_lat_max = 0; wr_lat_min = 0; wr_lat_max = 0;

        // Invalid geometry, then a valid run clears the error flag
        run_case("bad", 2, 10, 32'h0, 32'h0, 1'b0);
        run_case("t1b", 5, 6, 32'h1000, 32'h2000, 1'b0);

        // Reset in the middle of a write
        build_model(5, 6, 32'h1000, 32'h2000);
        clear_logs();
        cfg_n_rows = 5; cfg_n_cols = 6; cfg_in_base = 32'h1000; cfg_out_base = 32'h2000;
        go = 1'b1; cycle(); go = 1'b0;
        for (int k = 0; k < 200 && !write_en; k++) cycle();
        check("abort_saw_write", write_en, 1);
        reset = 1'b1;
        cycle();
        check("abort_ctl", {busy, done, cfg_err, rd_req, write_en, srow_op, write_mask}, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_wr_addr", write_addr, 0);
        reset = 1'b0;
        n_done = 0;
        repeat (5) cycle();
        check("abort_no_done", n_done, 0);
        run_case("restart", 5, 6, 32'h1000, 32'h2000, 1'b0);

        // go while busy must be ignored
        run_case("dup_go", 5, 6, 32'h1000, 32'h2000, 1'b1);

        // Randomised geometries and latencies
        rd_lat_min = 0; rd_lat_max = 3; wr_lat_min = 0; wr_lat_max = 2;
        for (int t = 0; t < 6; t++) begin
            run_case($sformatf("rnd%0d", t), $urandom_range(9, 3), $urandom_range(23, 3),
                     $urandom, $urandom, t[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
